mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative multiply/divide unit that owns the HI/LO register pair.
- Accepts MULT, MULTU, DIV and DIVU operations issued from the execute stage and computes each over multiple cycles.
- Holds HI/LO for subsequent MFHI/MFLO reads by the ALU, making it the producer side of the HI/LO interface the ALU consumes.
- Sits beside the ALU in EX; the pipeline stalls on busy.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width (must hold WIDTH).

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  issue strobe; sampled only when busy=0.
- funct  input  6  MIPS funct field of issued insn (MULT 011000, MULTU 011001, DIV 011010, DIVU 011011).
- rsData  input  WIDTH  operand A (multiplicand / dividend).
- rtData  input  WIDTH  operand B (multiplier / divisor).
- busy  output  1  operation in flight; EX must stall MFHI/MFLO and new MULT/DIV while high.
- done  output  1  one-cycle pulse; hi/lo carry the new result in this cycle.
- hi  output  WIDTH  HI register (product upper half / remainder).
- lo  output  WIDTH  LO register (product lower half / quotient).

Behaviour:
- Reset: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0. Reset mid-operation aborts the operation; no result is written.
- States: IDLE -> RUN -> FIX -> IDLE.
- IDLE:
  - start=1 with a recognised funct latches |rsData| and |rtData| (absolute values for signed ops; raw values for unsigned), the sign flags and the op, then moves to RUN with counter=0.
  - start=1 with any other funct is ignored.
- RUN: exactly WIDTH cycles.
  - Multiply: radix-2 shift-add over the 2*WIDTH accumulator.
  - Divide: restoring shift-subtract.
  - counter increments each cycle; leave RUN when counter==WIDTH-1.
- FIX: one cycle.
  - Multiply: negate the 2*WIDTH product if the operand signs differ (signed op only).
  - Divide: negate the quotient if the operand signs differ; the remainder takes the sign of the dividend.
  - hi/lo are written at the end of FIX. done=1 and busy=0 in the following cycle.
- Latency: start sampled at edge E0 -> busy=1 for cycles after E0..E33 -> hi/lo updated and done=1 in the cycle after E33 (33-cycle occupancy).
- start while busy=1 is ignored with no queuing. start in the same cycle as done=1 is accepted, since busy=0.
- hi/lo hold their value between operations and change only at FIX completion or reset.
- Divide by zero (rtData=0) is defined, not an error: lo=all ones, hi=rsData (raw). Full latency is kept.
- Signed overflow DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. Result wraps with no trap.
- All arithmetic is modulo 2^WIDTH per half; there are no exceptions.
- done is never asserted for an ignored start.

Decomposition:
- Shared package mips_pkg:
  - funct constants (MULT, MULTU, DIV, DIVU, MFHI, MFLO), already shared with the ALU.
  - Typedef for the md_state enum (IDLE, RUN, FIX).
  - Typedef for the md_op enum (OP_MUL, OP_DIV).
- One natural sub-module, md_iter_core: the unsigned per-cycle shift-add/shift-subtract datapath (accumulator, remainder, counter).
- The top-level handles sign stripping and fixing, the FSM, HI/LO and the handshake.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, start at E0 -> done exactly one cycle after E33; hi=0xFFFFFFFE, lo=0x00000001; busy low with done.
- MULT 0xFFFFFFFF × 0xFFFFFFFF (−1×−1) -> hi=0, lo=1. MULT 0xFFFFFFF9 × 2 (−7×2) -> hi=0xFFFFFFFF, lo=0xFFFFFFF2.
- DIV 0xFFFFFFF9 / 2 (−7/2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 0xFFFFFFF9 / 2 -> lo=0x7FFFFFFC, hi=1.
- Corner divides:
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
  - DIVU 123 / 0 -> lo=0xFFFFFFFF, hi=123.
- Second start with MULTU 3×4 at cycle 10 of a running op -> ignored; only the first result appears. Back-to-back: start with MULTU 3×4 in the done cycle -> accepted; hi=0, lo=12 after 33 more cycles.
- Reset asserted at cycle 15 of a DIV, after a prior result hi=5, lo=7 -> next cycle busy=0, hi=0, lo=0; no done pulse. start with funct=ADD (100000) -> no busy, no done, hi/lo unchanged.

Source files
------------

// File: rtl/mips_pkg.sv
// Decode constants and types shared by the ALU and the HI/LO multiply/divide unit.
package mips_pkg;

   localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
   localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
   localparam logic [5:0] FUNCT_MULT  = 6'b011000;
   localparam logic [5:0] FUNCT_MULTU = 6'b011001;
   localparam logic [5:0] FUNCT_DIV   = 6'b011010;
   localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIX
   } md_state;

   typedef enum logic {
      OP_MUL,
      OP_DIV
   } md_op;

   function automatic logic is_md_funct(input logic [5:0] f);
      return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
             (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
   endfunction

   function automatic logic is_signed_funct(input logic [5:0] f);
      return (f == FUNCT_MULT) || (f == FUNCT_DIV);
   endfunction

   function automatic md_op funct_to_op(input logic [5:0] f);
      return ((f == FUNCT_DIV) || (f == FUNCT_DIVU)) ? OP_DIV : OP_MUL;
   endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Issue/result bundle between the EX stage and the HI/LO multiply/divide unit.
interface mult_div_unit_if #(
   parameter int WIDTH = 32
);

   logic             start;
   logic [5:0]       funct;
   logic [WIDTH-1:0] rsData;
   logic [WIDTH-1:0] rtData;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   // EX stage issues operations and reads HI/LO.
   modport master (
      output start, funct, rsData, rtData,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, funct, rsData, rtData,
      output busy, done, hi, lo
   );

endinterface

// File: rtl/md_iter_core.sv
// Unsigned one-bit-per-cycle datapath: shift-add multiply or restoring divide.
module md_iter_core
   import mips_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               load,
   input  logic               step,
   input  md_op               op,
   input  logic [WIDTH-1:0]   init_lo,
   input  logic [WIDTH-1:0]   m,
   output logic [2*WIDTH-1:0] acc,
   output logic               last
);

   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   m_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     shifted;
   logic               fits;

   // Multiply keeps {partial, multiplier}; divide keeps {remainder, dividend/quotient}.
   always_comb begin
      sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
      shifted = acc_q[2*WIDTH-1:WIDTH-1];
      fits    = (shifted >= {1'b0, m_q});
      if (op == OP_MUL) begin
         acc_d = {sum, acc_q[WIDTH-1:1]};
      end else begin
         acc_d = {(fits ? WIDTH'(shifted - {1'b0, m_q}) : shifted[WIDTH-1:0]),
                  acc_q[WIDTH-2:0], fits};
      end
   end

   always_ff @(posedge clock) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         acc_q <= '0;
         m_q   <= '0;
         cnt_q <= '0;
      end else if (load) begin
         acc_q <= {{WIDTH{1'b0}}, init_lo};
         m_q   <= m;
         cnt_q <= '0;
      end else if (step) begin
         acc_q <= acc_d;
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign acc  = acc_q;
   assign last = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; strips signs on issue and
// restores them in a single fix-up cycle after WIDTH iterations.
module mult_div_unit
   import mips_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic          clock,
   input  logic          reset,
   mult_div_unit_if.slave md
);

   md_state            state_q, state_d;
   md_op               op_q, op_in;
   logic               neg_a_q, neg_b_q, bzero_q;
   logic               neg_a_in, neg_b_in, sgn_in;
   logic               issue, step, last, done_q;
   logic [WIDTH-1:0]   a_mag, b_mag, core_lo, core_m;
   logic [WIDTH-1:0]   hi_q, lo_q, fix_hi, fix_lo;
   logic [2*WIDTH-1:0] acc, prod;

   // Operands are reduced to magnitudes; sign flags are zero for unsigned ops.
   assign issue    = md.start && (state_q == IDLE) && is_md_funct(md.funct);
   assign op_in    = funct_to_op(md.funct);
   assign sgn_in   = is_signed_funct(md.funct);
   assign neg_a_in = sgn_in && md.rsData[WIDTH-1];
   assign neg_b_in = sgn_in && md.rtData[WIDTH-1];
   assign a_mag    = neg_a_in ? -md.rsData : md.rsData;
   assign b_mag    = neg_b_in ? -md.rtData : md.rtData;
   assign core_lo  = (op_in == OP_MUL) ? b_mag : a_mag;
   assign core_m   = (op_in == OP_MUL) ? a_mag : b_mag;

   md_iter_core #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_core (
      .clock   (clock),
      .reset   (reset),
      .load    (issue),
      .step    (step),
      .op      (op_q),
      .init_lo (core_lo),
      .m       (core_m),
      .acc     (acc),
      .last    (last)
   );

   always_comb begin
      // NOTE: defaults first so no path leaves a signal unassigned (no latch).
      state_d = state_q;
      step    = 1'b0;
      unique case (state_q)
         IDLE: if (issue) state_d = RUN;
         RUN: begin
            step = 1'b1;
            if (last) state_d = FIX;
         end
         FIX:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A zero divisor keeps the all-ones quotient unsigned; the remainder then
   // reconstructs rsData exactly once its sign is restored.
   always_comb begin
      prod   = (neg_a_q ^ neg_b_q) ? -acc : acc;
      fix_hi = prod[2*WIDTH-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
      if (op_q == OP_DIV) begin
         fix_lo = ((neg_a_q ^ neg_b_q) && !bzero_q) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
         fix_hi = neg_a_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         op_q    <= OP_MUL;
         neg_a_q <= 1'b0;
         neg_b_q <= 1'b0;
         bzero_q <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= (state_q == FIX);
         if (issue) begin
            op_q    <= op_in;
            neg_a_q <= neg_a_in;
            neg_b_q <= neg_b_in;
            bzero_q <= (md.rtData == '0);
         end
         if (state_q == FIX) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
         end
      end
   end

   assign md.busy = (state_q != IDLE);
   assign md.done = done_q;
   assign md.hi   = hi_q;
   assign md.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed corner cases plus random ops
// against an arithmetic reference model.
module tb_mult_div_unit;
   import mips_pkg::*;

   localparam int W = 32;

   typedef struct {
      int unsigned    edge_n;
      logic [W-1:0]   hi;
      logic [W-1:0]   lo;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset;
   int unsigned cyc = 0;
   int          tests = 0;
   int          fails = 0;
   int          done_cnt = 0;
   exp_t        sb_q[$];

   mult_div_unit_if #(.WIDTH(W)) md ();

   mult_div_unit #(
      .WIDTH (W),
      .CNT_W (6)
   ) dut (
      .clock (clock),
      .reset (reset),
      .md    (md)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [63:0] model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
      longint p;
      int     sa, sb;
      sa = $signed(a);
      sb = $signed(b);
      case (f)
         FUNCT_MULT: begin
            p = longint'(sa) * longint'(sb);
            return p;
         end
         FUNCT_MULTU: return {32'h0, a} * {32'h0, b};
         FUNCT_DIV: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && sb == -1) return {32'h0, 32'h8000_0000};
            return {32'(sa % sb), 32'(sa / sb)};
         end
         FUNCT_DIVU: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         default: return 64'h0;
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      tests++;
      if (act !== exp_v) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   // Called at a falling edge; start is sampled on the next rising edge.
   task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b, input bit expect_res);
      logic [63:0] r;
      exp_t        e;
      md.start  = 1'b1;
      md.funct  = f;
      md.rsData = a;
      md.rtData = b;
      if (expect_res) begin
         r = model(f, a, b);
         e.edge_n = cyc + 1;
         e.hi     = r[63:32];
         e.lo     = r[31:0];
         sb_q.push_back(e);
      end
      @(posedge clock);
      #1;
      md.start = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clock);
         if (sb_q.size() == 0 && md.busy === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         tests++;
         fails++;
         $display("FAIL wait_idle_timeout: got %0d pending results, expected 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   function automatic logic [W-1:0] rand_operand();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return W'($urandom_range(0, 15));
         default: return W'($urandom);
      endcase
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clock) begin
      exp_t e;
      if (reset === 1'b0 && md.done === 1'b1) begin
         done_cnt++;
         if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pulse", cyc);
         end else begin
            e = sb_q.pop_front();
            check("result_hi", 64'(md.hi), 64'(e.hi));
            check("result_lo", 64'(md.lo), 64'(e.lo));
            check("done_latency", 64'(cyc), 64'(e.edge_n + 33));
            check("busy_low_with_done", 64'(md.busy), 64'(0));
         end
      end
   end

   initial begin
      logic [5:0]  dir_f[6];
      logic [W-1:0] dir_a[6];
      logic [W-1:0] dir_b[6];
      logic [5:0]  ops[4];
      logic [63:0] r;
      int          d0;
      bit          got;

      dir_f = '{FUNCT_MULT, FUNCT_MULT, FUNCT_DIV, FUNCT_DIVU, FUNCT_DIV, FUNCT_DIVU};
      dir_a = '{32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000, 32'd123};
      dir_b = '{32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2, 32'hFFFF_FFFF, 32'd0};
      ops   = '{FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU};

      reset     = 1'b1;
      md.start  = 1'b0;
      md.funct  = 6'h0;
      md.rsData = '0;
      md.rtData = '0;
      repeat (3) @(negedge clock);
      check("reset_busy", 64'(md.busy), 64'(0));
      check("reset_done", 64'(md.done), 64'(0));
      check("reset_hi", 64'(md.hi), 64'(0));
      check("reset_lo", 64'(md.lo), 64'(0));
      reset = 1'b0;

      // Start while busy is dropped: exactly one result appears.
      d0 = done_cnt;
      @(negedge clock);
      issue(FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      repeat (8) @(negedge clock);
      check("busy_mid_op", 64'(md.busy), 64'(1));
      issue(FUNCT_MULTU, 32'd3, 32'd4, 1'b0);
      wait_idle();
      repeat (40) @(negedge clock);
      check("ignored_start_done_count", 64'(done_cnt - d0), 64'(1));

      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         issue(dir_f[i], dir_a[i], dir_b[i], 1'b1);
         wait_idle();
      end

      // Start in the done cycle is accepted.
      @(negedge clock);
      issue(FUNCT_MULTU, 32'd7, 32'd9, 1'b1);
      got = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clock);
         if (md.done === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      check("b2b_done_seen", 64'(got), 64'(1));
      issue(FUNCT_MULTU, 32'd3, 32'd4, 1'b1);
      wait_idle();

      // Reset mid-divide aborts with no result.
      @(negedge clock);
      issue(FUNCT_DIVU, 32'd47, 32'd6, 1'b1);
      wait_idle();
      @(negedge clock);
      d0 = done_cnt;
      issue(FUNCT_DIV, 32'd1000, 32'd3, 1'b0);
      repeat (14) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("abort_busy", 64'(md.busy), 64'(0));
      check("abort_hi", 64'(md.hi), 64'(0));
      check("abort_lo", 64'(md.lo), 64'(0));
      reset = 1'b0;
      repeat (45) @(negedge clock);
      check("abort_no_done", 64'(done_cnt - d0), 64'(0));

      // Unrecognised funct is ignored and HI/LO hold.
      @(negedge clock);
      issue(FUNCT_DIVU, 32'd47, 32'd6, 1'b1);
      wait_idle();
      r  = model(FUNCT_DIVU, 32'd47, 32'd6);
      d0 = done_cnt;
      @(negedge clock);
      issue(6'b100000, 32'd55, 32'd66, 1'b0);
      @(negedge clock);
      check("bad_funct_busy", 64'(md.busy), 64'(0));
      repeat (40) @(negedge clock);
      check("bad_funct_no_done", 64'(done_cnt - d0), 64'(0));
      check("hold_hi", 64'(md.hi), 64'(r[63:32]));
      check("hold_lo", 64'(md.lo), 64'(r[31:0]));

      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         issue(ops[$urandom_range(0, 3)], rand_operand(), rand_operand(), 1'b1);
         wait_idle();
      end

      check("scoreboard_drained", 64'(sb_q.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
